// File: rtl/capture_pkg.sv
// Shared constants, state encoding and address helper
// for the camera frame capture block.
package capture_pkg;

  localparam int H_BYTES_DEF = 1280;
  localparam int V_LINES_DEF = 480;
  localparam int DECIM_DEF   = 4;
  localparam int OUT_W       = 160;
  localparam int OUT_H       = 120;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  // row*160 + col as two shifts and adds
  function automatic logic [14:0] fb_addr(
    input logic [8:0]  row,
    input logic [10:0] col
  );
    logic [14:0] r;
    r = {6'b0, row};
    return (r << 7) + (r << 5) + {4'b0, col};
  endfunction

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchronizer for the camera bus plus
// pclk / h_ref / v_sync edge detection.
module cam_sync (
  input  logic       clk_25,
  input  logic       reset,
  input  logic       pclk,
  input  logic       h_ref,
  input  logic       v_sync,
  input  logic [7:0] data_in,
  output logic       pclk_rise,
  output logic       href_lvl,
  output logic       href_fall,
  output logic       vs_rise,
  output logic       vs_fall,
  output logic [7:0] data_s
);

  logic [10:0] s1;
  logic [10:0] s2;
  logic [2:0]  prev;
  logic [2:0]  fill;
  logic        primed;

  always_ff @(posedge clk_25) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      fill <= '0;
    end else begin
      s1   <= {pclk, h_ref, v_sync, data_in};
      s2   <= s1;
      prev <= s2[10:8];
      fill <= {fill[1:0], 1'b1};
    end
  end

  // edges only once both s2 and prev hold real samples
  assign primed    = fill[2];
  assign pclk_rise = primed & s2[10] & ~prev[2];
  assign href_fall = primed & ~s2[9] & prev[1];
  assign vs_rise   = primed & s2[8] & ~prev[0];
  assign vs_fall   = primed & ~s2[8] & prev[0];
  assign href_lvl  = s2[9];
  assign data_s    = s2[7:0];

endmodule

// File: rtl/capture_ctrl.sv
// Camera frame capture: decimates a synced camera stream
// into 2-bit pixels written to a 160x120 frame buffer.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int H_BYTES = H_BYTES_DEF,
  parameter int V_LINES = V_LINES_DEF,
  parameter int DECIM   = DECIM_DEF
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        start,
  input  logic        pclk,
  input  logic        h_ref,
  input  logic        v_sync,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic        wr_en,
  output logic [14:0] wr_addr,
  output logic [1:0]  wr_data,
  output logic        frame_done,
  output logic        short_frame
);

  localparam int CSH = $clog2(2 * DECIM);
  localparam int RSH = $clog2(DECIM);
  localparam logic [10:0] BMASK = 11'(2 * DECIM - 1);
  localparam logic [8:0]  LMASK = 9'(DECIM - 1);
  localparam logic [10:0] HB_L  = 11'(H_BYTES);
  localparam logic [8:0]  VL_L  = 9'(V_LINES);

  logic       pclk_rise;
  logic       href_s;
  logic       href_fall;
  logic       vs_rise;
  logic       vs_fall;
  logic [7:0] cam_data;
  logic       unused_low;

  cap_state_t  st;
  logic [10:0] byte_cnt;
  logic [8:0]  line_cnt;
  logic [8:0]  line_nxt;
  logic [10:0] col;
  logic [8:0]  row;
  logic        in_win;
  logic        take;

  cam_sync u_sync (
    .clk_25    (clk_25),
    .reset     (reset),
    .pclk      (pclk),
    .h_ref     (h_ref),
    .v_sync    (v_sync),
    .data_in   (data_in),
    .pclk_rise (pclk_rise),
    .href_lvl  (href_s),
    .href_fall (href_fall),
    .vs_rise   (vs_rise),
    .vs_fall   (vs_fall),
    .data_s    (cam_data)
  );

  assign unused_low = ^cam_data[5:0];

  assign col = byte_cnt >> CSH;
  assign row = line_cnt >> RSH;

  assign in_win = (byte_cnt < HB_L)
               && (line_cnt < VL_L)
               && (col < 11'(OUT_W))
               && (row < 9'(OUT_H));

  assign take = pclk_rise && href_s
             && ((byte_cnt & BMASK) == '0)
             && ((line_cnt & LMASK) == '0)
             && in_win;

  // empty h_ref pulses do not count as lines
  assign line_nxt =
    (href_fall && byte_cnt != '0 && line_cnt != '1)
      ? line_cnt + 9'd1 : line_cnt;

  always_ff @(posedge clk_25) begin
    if (reset) begin
      st          <= IDLE;
      busy        <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      byte_cnt    <= '0;
      line_cnt    <= '0;
    end else begin
      wr_en <= 1'b0;
      unique case (st)
        IDLE: begin
          if (start) begin
            st   <= ARM;
            busy <= 1'b1;
          end
        end
        ARM: begin
          if (vs_fall) begin
            st       <= CAPTURE;
            byte_cnt <= '0;
            line_cnt <= '0;
          end
        end
        CAPTURE: begin
          if (vs_rise) begin
            st          <= DONE;
            frame_done  <= 1'b1;
            short_frame <= (line_nxt < VL_L);
          end else begin
            if (pclk_rise && href_s && byte_cnt != '1)
              byte_cnt <= byte_cnt + 11'd1;
            if (href_fall) begin
              byte_cnt <= '0;
              line_cnt <= line_nxt;
            end
            if (take) begin
              wr_en   <= 1'b1;
              wr_addr <= fb_addr(row, col);
              wr_data <= cam_data[7:6];
            end
          end
        end
        DONE: begin
          st         <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl on a reduced
// camera geometry driven by a byte-level camera model.
module tb_capture_ctrl;
  import capture_pkg::*;

  localparam int HB  = 48;
  localparam int VL  = 16;
  localparam int DEC = 4;
  localparam int NW  = (VL / DEC) * (HB / (2 * DEC));

  logic        clk_25 = 1'b0;
  logic        reset;
  logic        start;
  logic        pclk;
  logic        h_ref;
  logic        v_sync;
  logic [7:0]  data_in;
  logic        busy;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [1:0]  wr_data;
  logic        frame_done;
  logic        short_frame;

  always #20 clk_25 = ~clk_25;

  capture_ctrl #(
    .H_BYTES (HB),
    .V_LINES (VL),
    .DECIM   (DEC)
  ) dut (
    .clk_25      (clk_25),
    .reset       (reset),
    .start       (start),
    .pclk        (pclk),
    .h_ref       (h_ref),
    .v_sync      (v_sync),
    .data_in     (data_in),
    .busy        (busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .short_frame (short_frame)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          n_wr = 0;
  int          n_done = 0;
  logic        last_short = 1'b0;
  logic [16:0] sb[$];
  logic [1:0]  fbuf[int];
  bit          use_pat = 1'b0;
  bit          cap_on = 1'b0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_25) begin
    if (wr_en) begin
      n_wr++;
      fbuf[int'(wr_addr)] = wr_data;
      if (sb.size() == 0)
        chk("wr_unexp", 32'(sb.size()), 32'd1);
      else
        chk("wr", {15'b0, wr_addr, wr_data},
            {15'b0, sb.pop_front()});
    end
    if (frame_done) begin
      n_done++;
      last_short = short_frame;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk_25);
  endtask

  function automatic logic [7:0] byte_val(int ln, int b);
    if (!use_pat) return 8'($urandom_range(0, 255));
    if (ln == 0 && b == 0) return 8'hC0;
    if (ln == 0 && b < 8) return 8'h11;
    if (ln == 4 && b == 8) return 8'h40;
    return 8'h00;
  endfunction

  function automatic bit selected(int ln, int b);
    return (ln % DEC == 0) && (b % (2 * DEC) == 0)
        && (b < HB) && (ln < VL)
        && (b / (2 * DEC) < OUT_W) && (ln / DEC < OUT_H);
  endfunction

  task automatic put_byte(int ln, int b);
    logic [7:0]  v;
    logic [14:0] a;
    v = byte_val(ln, b);
    data_in = v;
    pclk = 1'b0;
    tick(2);
    if (cap_on && selected(ln, b)) begin
      a = 15'((ln / DEC) * OUT_W + b / (2 * DEC));
      sb.push_back({a, v[7:6]});
    end
    pclk = 1'b1;
    tick(2);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // ev_kind: 0 none, 1 start pulse, 2 reset pulse
  task automatic run_frame(int nl, int nb,
                           int ev_line, int ev_kind);
    v_sync = 1'b0;
    tick(6);
    for (int ln = 0; ln < nl; ln++) begin
      h_ref = 1'b1;
      for (int b = 0; b < nb; b++) begin
        if (ln == ev_line && b == nb / 2) begin
          if (ev_kind == 1) begin
            pulse_start();
            chk("mid_start_busy", 32'(busy), 32'd1);
          end else if (ev_kind == 2) begin
            cap_on = 1'b0;
            reset = 1'b1;
            tick(1);
            reset = 1'b0;
            chk("rst_busy", 32'(busy), 32'd0);
          end
        end
        put_byte(ln, b);
      end
      pclk = 1'b0;
      h_ref = 1'b0;
      tick(4);
    end
    v_sync = 1'b1;
    tick(10);
  endtask

  task automatic frame_checks(string t, int w0, int d0,
                              int exp_wr, int exp_done,
                              bit exp_short);
    chk({t, "_nwr"}, 32'(n_wr - w0), 32'(exp_wr));
    chk({t, "_done"}, 32'(n_done - d0), 32'(exp_done));
    if (exp_done > 0)
      chk({t, "_short"}, 32'(last_short), 32'(exp_short));
    chk({t, "_busy"}, 32'(busy), 32'd0);
    chk({t, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w0;
    int d0;
    reset = 1'b1;
    start = 1'b0;
    pclk = 1'b1;
    h_ref = 1'b0;
    v_sync = 1'b1;
    data_in = 8'h00;
    tick(3);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_short", 32'(short_frame), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    reset = 1'b0;
    tick(4);

    // full frame
    w0 = n_wr; d0 = n_done;
    pulse_start();
    chk("arm_busy", 32'(busy), 32'd1);
    cap_on = 1'b1;
    run_frame(VL, HB, -1, 0);
    frame_checks("full", w0, d0, NW, 1, 1'b0);

    // pixel selection pattern
    w0 = n_wr; d0 = n_done;
    use_pat = 1'b1;
    fbuf.delete();
    pulse_start();
    run_frame(5, 16, -1, 0);
    frame_checks("pix", w0, d0, 4, 1, 1'b1);
    chk("pix_a0", 32'(fbuf[0]), 32'd3);
    chk("pix_a1", 32'(fbuf[1]), 32'd0);
    chk("pix_a160", 32'(fbuf[160]), 32'd0);
    chk("pix_a161", 32'(fbuf[161]), 32'd1);
    use_pat = 1'b0;

    // start in the middle of a running frame
    w0 = n_wr; d0 = n_done;
    cap_on = 1'b0;
    run_frame(VL, HB, 6, 1);
    chk("mid_nwr0", 32'(n_wr - w0), 32'd0);
    chk("mid_armed", 32'(busy), 32'd1);
    cap_on = 1'b1;
    run_frame(VL, HB, -1, 0);
    frame_checks("mid", w0, d0, NW, 1, 1'b0);

    // short frame
    w0 = n_wr; d0 = n_done;
    pulse_start();
    run_frame(VL / 2, HB, -1, 0);
    frame_checks("short", w0, d0, NW / 2, 1, 1'b1);

    // overlong lines and frame
    w0 = n_wr; d0 = n_done;
    pulse_start();
    run_frame(VL + 4, HB + 8, -1, 0);
    frame_checks("long", w0, d0, NW, 1, 1'b0);

    // reset in the middle of a capture
    w0 = n_wr; d0 = n_done;
    pulse_start();
    run_frame(VL, HB, 5, 2);
    frame_checks("rstcap", w0, d0, NW / 2, 0, 1'b0);

    // no start: frame must be ignored
    w0 = n_wr; d0 = n_done;
    cap_on = 1'b0;
    run_frame(VL / 2, HB, -1, 0);
    frame_checks("idle", w0, d0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter H_BYTES, default 1280, camera bytes per active line (640 px x 2 bytes).
REQ-002 SHALL have parameter V_LINES, default 480, camera active lines per frame.
REQ-003 SHALL have parameter DECIM, default 4, decimation factor applied to both axes.
REQ-004 SHALL have port clk_25  in  1  system clock; the only clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse arming capture of the next full frame.
REQ-007 SHALL have port pclk  in  1  camera pixel clock, asynchronous, sampled as data.
REQ-008 SHALL have port h_ref  in  1  camera line-valid, asynchronous.
REQ-009 SHALL have port v_sync  in  1  camera frame sync, asynchronous, high between frames.
REQ-010 SHALL have port data_in  in  8  camera byte, asynchronous.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port wr_en  out  1  one-cycle frame-buffer write strobe.
REQ-013 SHALL have port wr_addr  out  15  frame-buffer address, row*160+col.
REQ-014 SHALL have port wr_data  out  2  pixel value, data_in[7:6] of the sampled byte.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse at end of capture.
REQ-016 SHALL have port short_frame  out  1  valid with frame_done; high if fewer than V_LINES lines were seen.

Function
REQ-017 SHALL pass pclk, h_ref, v_sync and data_in through identical 2-flop synchronizers, keeping them mutually aligned.
REQ-018 SHALL detect a pclk rising edge as synced=1 and previous synced=0; pclk frequency SHALL be at most clk_25/4.
REQ-019 SHALL implement FSM IDLE -> ARM (on start) -> CAPTURE (on synced v_sync falling edge) -> DONE (one cycle) -> IDLE.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 SHALL, in ARM, ignore all camera data, so a frame already in progress when start arrives is never captured partially.
REQ-022 SHALL, in CAPTURE, increment an 11-bit byte_cnt on each pclk edge while synced h_ref=1.
REQ-023 SHALL, on a synced h_ref falling edge, clear byte_cnt; it SHALL increment a 9-bit line_cnt only if byte_cnt was nonzero.
REQ-024 SHALL compute col = byte_cnt[10:3] and row = line_cnt[8:2], i.e. the first byte of every 4th pixel pair on every 4th line.
REQ-025 SHALL issue a write only when byte_cnt[2:0]=0, line_cnt[1:0]=0, col<160 and row<120; bytes beyond H_BYTES and lines beyond V_LINES SHALL produce no write.
REQ-026 SHALL compute wr_addr = row*128 + row*32 + col using shift-add only, with no multiplier.
REQ-027 SHALL register wr_en, wr_addr and wr_data in the cycle after the edge-detect cycle, making latency from synced pclk edge to wr_en exactly 1 cycle.
REQ-028 SHALL leave CAPTURE on a synced v_sync rising edge; a same-cycle pclk edge SHALL NOT write.
REQ-029 SHALL set short_frame = (line_cnt < V_LINES) at exit from CAPTURE.
REQ-030 SHALL assert frame_done for exactly the DONE cycle.
REQ-031 SHALL clear byte_cnt and line_cnt on entry to CAPTURE.

Reset
REQ-032 SHALL, while reset=1 at a clock edge, enter IDLE and set busy, wr_en, frame_done and short_frame to 0, wr_addr to 0, wr_data to 0, the counters to 0 and the synchronizer flops to 0.
REQ-033 SHALL abandon a capture in progress on reset with no frame_done.
REQ-034 SHALL NOT treat the first post-reset synced pclk=1 sample as an edge.

Structure
REQ-035 SHALL place H_BYTES/V_LINES/DECIM defaults, OUT_W=160, OUT_H=120 and the FSM state encoding in shared package capture_pkg.
REQ-036 SHALL place one sub-module, cam_sync, holding the 4-signal 2-flop synchronizer plus pclk edge and h_ref/v_sync edge detectors.

Verification
REQ-037 SHALL cover a full frame: start, then 480 lines x 1280 bytes -> exactly 19200 writes, wr_addr 0..19199 ascending, frame_done=1, short_frame=0.
REQ-038 SHALL cover pixel selection: line 0, bytes 0x00..0x07 = 0xC0,0x11,... -> single write addr 0, data 2'b11; line 4, byte 8 = 0x40 -> write addr 161, data 2'b01.
REQ-039 SHALL cover a mid-frame start: start asserted during line 200 of a running frame -> no writes until the next v_sync falling edge, then a full 19200-write frame.
REQ-040 SHALL cover a short frame: v_sync rises after 300 lines -> 75x160 = 12000 writes, frame_done with short_frame=1, back to IDLE.
REQ-041 SHALL cover overlong lines and frames: 1400-byte lines and 500 lines -> still exactly 19200 writes, none with col>=160 or row>=120.
REQ-042 SHALL cover reset mid-capture: reset for 1 cycle during line 100 -> busy=0 next cycle, no frame_done, no further writes until a new start.
